// File: rtl/textlcd_pkg.sv
// textlcd_pkg: shared constants and FSM encoding for the character-LCD controller.
//   - HD44780 command bytes and the blank character code
//   - state_e: controller sequencing states
//   - ddram_cmd(): builds the "set DDRAM address" command for a row start
package textlcd_pkg;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_DDRAM    = 8'h80;
  localparam logic [7:0] ROW2_OFS     = 8'h40;
  localparam logic [7:0] CHAR_SPACE   = 8'h20;

  // S_CLRWAIT holds the idle steps that follow the clear command.
  typedef enum logic [3:0] {
    S_POWERUP = 4'd0,
    S_FUNC    = 4'd1,
    S_DISP    = 4'd2,
    S_ENTRY   = 4'd3,
    S_CLEAR   = 4'd4,
    S_CLRWAIT = 4'd5,
    S_ADDR    = 4'd6,
    S_CHAR    = 4'd7,
    S_IDLE    = 4'd8
  } state_e;

  // DDRAM address command for the first column of a row (row 1 starts at 8'h40).
  function automatic logic [7:0] ddram_cmd(input logic row);
    return CMD_DDRAM | (row ? ROW2_OFS : 8'h00);
  endfunction

endpackage

// File: rtl/textlcd_if.sv
// textlcd_if: host-side write port of the character-LCD controller.
//   wr_en/wr_addr/wr_data : single-cycle character write into the buffer
//   clear_req             : one-cycle request to blank buffer and panel
//   busy                  : controller is not idle
// AW carries one bit more than the buffer index needs so that out-of-range
// addresses can actually be presented and are visibly ignored.
interface textlcd_if #(
  parameter int AW = 4
) ();
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          clear_req;
  logic          busy;

  modport master (output wr_en, output wr_addr, output wr_data, output clear_req, input busy);
  modport slave  (input wr_en, input wr_addr, input wr_data, input clear_req, output busy);
endinterface

// File: rtl/textlcd_ctrl_timer.sv
// lcd_step_timer: divides clk into LCD bus steps of TICK_DIV cycles.
//   clk, resetn : clock, async active-low reset
//   pulse_en    : current step carries a bus transaction (valid from count 0)
//   step_end    : last cycle of the step (count TICK_DIV-1)
//   lcd_e       : registered E strobe, high for counts 1..TICK_DIV/2 of enabled steps
module lcd_step_timer #(
  parameter int TICK_DIV = 50
) (
  input  logic clk,
  input  logic resetn,
  input  logic pulse_en,
  output logic step_end,
  output logic lcd_e
);

  localparam int CNTW = $clog2(TICK_DIV);
  localparam int HALF = TICK_DIV / 2;

  logic [CNTW-1:0] cnt_r;
  logic            step_start_s;
  logic            e_r;

  assign step_start_s = (cnt_r == '0);
  assign step_end     = (cnt_r == CNTW'(TICK_DIV - 1));
  assign lcd_e        = e_r;

  // Step counter, wraps at the terminal count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r <= '0;
    end else if (step_end) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNTW'(1);
    end
  end

  // E rises entering count 1 and falls entering count HALF+1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      e_r <= 1'b0;
    end else if (step_start_s && pulse_en) begin
      e_r <= 1'b1;
    end else if (cnt_r == CNTW'(HALF)) begin
      e_r <= 1'b0;
    end else begin
      e_r <= e_r;
    end
  end

endmodule

// File: rtl/textlcd_ctrl.sv
// textlcd_ctrl: HD44780-style character-LCD controller.
//   clk, resetn       : system clock, async active-low reset
//   host (slave)      : character writes, clear request, busy
//   LCD_E/RS/RW/DATA  : panel bus; RW is tied low (write-only)
// Runs the power-up init sequence, then refreshes ROWS x COLS characters from
// an internal buffer, re-running a pass early when the buffer was written.
module textlcd_ctrl
  import textlcd_pkg::*;
#(
  parameter int COLS          = 16,
  parameter int ROWS          = 2,
  parameter int TICK_DIV      = 50,
  parameter int INIT_STEPS    = 70,
  parameter int CLEAR_STEPS   = 200,
  parameter int REFRESH_STEPS = 400
) (
  input  logic       clk,
  input  logic       resetn,
  textlcd_if.slave   host,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA
);

  localparam int NCHR = ROWS * COLS;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;

  logic [7:0]    buf_r [NCHR];
  state_e        state_r, state_n_s;
  logic          row_r, row_n_s;
  logic [CW-1:0] col_r, col_n_s;
  logic [15:0]   wait_r, wait_n_s;
  logic          dirty_r, pend_r;
  logic          pass_start_s, clr_start_s;
  logic          active_r, active_n_s;
  logic          rs_r, rs_n_s;
  logic [7:0]    data_r, data_n_s, rd_data_s;
  logic          busy_r;
  logic          step_end_s;
  logic          wr_hit_s;

  assign wr_hit_s  = host.wr_en && (32'(host.wr_addr) < 32'(NCHR));
  assign host.busy = busy_r;
  assign LCD_RS    = rs_r;
  assign LCD_DATA  = data_r;
  assign LCD_RW    = 1'b0;

  lcd_step_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk      (clk),
    .resetn   (resetn),
    .pulse_en (active_r),
    .step_end (step_end_s),
    .lcd_e    (LCD_E)
  );

  // Character buffer: clear blanks everything, a same-cycle write then overrides its byte.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NCHR; i++) buf_r[i] <= CHAR_SPACE;
    end else begin
      for (int i = 0; i < NCHR; i++) begin
        if (wr_hit_s && (32'(host.wr_addr) == 32'(i))) begin
          buf_r[i] <= host.wr_data;
        end else if (host.clear_req) begin
          buf_r[i] <= CHAR_SPACE;
        end else begin
          buf_r[i] <= buf_r[i];
        end
      end
    end
  end

  // Dirty and clear-pending flags; a new request wins over the clear at service time.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dirty_r <= 1'b0;
      pend_r  <= 1'b0;
    end else begin
      if (wr_hit_s) dirty_r <= 1'b1;
      else if (step_end_s && pass_start_s) dirty_r <= 1'b0;
      else dirty_r <= dirty_r;
      if (host.clear_req) pend_r <= 1'b1;
      else if (step_end_s && clr_start_s) pend_r <= 1'b0;
      else pend_r <= pend_r;
    end
  end

  // Buffer byte for the next step's row/column.
  always_comb begin
    rd_data_s = CHAR_SPACE;
    for (int i = 0; i < NCHR; i++) begin
      rd_data_s = ((int'(row_n_s) * COLS + int'(col_n_s)) == i) ? buf_r[i] : rd_data_s;
    end
  end

  // Next state and counters, applied at step end.
  always_comb begin
    state_n_s    = state_r;
    row_n_s      = row_r;
    col_n_s      = col_r;
    wait_n_s     = wait_r;
    pass_start_s = 1'b0;
    clr_start_s  = 1'b0;
    case (state_r)
      S_POWERUP: begin
        if (wait_r == 16'(INIT_STEPS - 1)) begin
          state_n_s = S_FUNC;
          wait_n_s  = 16'd0;
        end else begin
          wait_n_s = wait_r + 16'd1;
        end
      end
      S_FUNC:  state_n_s = S_DISP;
      S_DISP:  state_n_s = S_ENTRY;
      S_ENTRY: begin
        state_n_s   = S_CLEAR;
        clr_start_s = 1'b1;
      end
      S_CLEAR: begin
        state_n_s = S_CLRWAIT;
        wait_n_s  = 16'd0;
      end
      S_CLRWAIT: begin
        if (wait_r == 16'(CLEAR_STEPS - 1)) begin
          state_n_s    = S_ADDR;
          row_n_s      = 1'b0;
          col_n_s      = '0;
          wait_n_s     = 16'd0;
          pass_start_s = 1'b1;
        end else begin
          wait_n_s = wait_r + 16'd1;
        end
      end
      S_ADDR: begin
        state_n_s = S_CHAR;
        col_n_s   = '0;
      end
      S_CHAR: begin
        if (col_r == CW'(COLS - 1)) begin
          col_n_s = '0;
          if (row_r == 1'(ROWS - 1)) begin
            state_n_s = S_IDLE;
            row_n_s   = 1'b0;
            wait_n_s  = 16'd0;
          end else begin
            state_n_s = S_ADDR;
            row_n_s   = row_r + 1'b1;
          end
        end else begin
          col_n_s = col_r + CW'(1);
        end
      end
      S_IDLE: begin
        if (pend_r) begin
          state_n_s   = S_CLEAR;
          clr_start_s = 1'b1;
        end else if (dirty_r || (wait_r == 16'(REFRESH_STEPS - 1))) begin
          state_n_s    = S_ADDR;
          row_n_s      = 1'b0;
          col_n_s      = '0;
          wait_n_s     = 16'd0;
          pass_start_s = 1'b1;
        end else begin
          wait_n_s = wait_r + 16'd1;
        end
      end
      default: begin
        state_n_s = S_POWERUP;
        wait_n_s  = 16'd0;
      end
    endcase
  end

  // Bus contents for the next step; idle steps keep the previous RS/DATA.
  always_comb begin
    active_n_s = 1'b0;
    rs_n_s     = rs_r;
    data_n_s   = data_r;
    case (state_n_s)
      S_FUNC:  begin active_n_s = 1'b1; rs_n_s = 1'b0; data_n_s = CMD_FUNC_SET; end
      S_DISP:  begin active_n_s = 1'b1; rs_n_s = 1'b0; data_n_s = CMD_DISP_ON;  end
      S_ENTRY: begin active_n_s = 1'b1; rs_n_s = 1'b0; data_n_s = CMD_ENTRY;    end
      S_CLEAR: begin active_n_s = 1'b1; rs_n_s = 1'b0; data_n_s = CMD_CLEAR;    end
      S_ADDR:  begin active_n_s = 1'b1; rs_n_s = 1'b0; data_n_s = ddram_cmd(row_n_s); end
      S_CHAR:  begin active_n_s = 1'b1; rs_n_s = 1'b1; data_n_s = rd_data_s;    end
      default: begin active_n_s = 1'b0; rs_n_s = rs_r; data_n_s = data_r;      end
    endcase
  end

  // State, counters and registered bus outputs, all updated at step end.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r  <= S_POWERUP;
      row_r    <= 1'b0;
      col_r    <= '0;
      wait_r   <= 16'd0;
      active_r <= 1'b0;
      rs_r     <= 1'b0;
      data_r   <= 8'h00;
      busy_r   <= 1'b1;
    end else if (step_end_s) begin
      state_r  <= state_n_s;
      row_r    <= row_n_s;
      col_r    <= col_n_s;
      wait_r   <= wait_n_s;
      active_r <= active_n_s;
      rs_r     <= rs_n_s;
      data_r   <= data_n_s;
      busy_r   <= (state_n_s != S_IDLE);
    end else begin
      state_r  <= state_r;
      row_r    <= row_r;
      col_r    <= col_r;
      wait_r   <= wait_r;
      active_r <= active_r;
      rs_r     <= rs_r;
      data_r   <= data_r;
      busy_r   <= busy_r;
    end
  end

endmodule

// File: tb/tb_textlcd_ctrl.sv
// tb_textlcd_ctrl: directed bench for textlcd_ctrl (COLS=4, ROWS=2, TICK_DIV=4).
// A negedge monitor decodes each E pulse into {RS,DATA} with its cycle number;
// the test sequence compares those against hand-built expected streams.
module tb_textlcd_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       LCD_E, LCD_RS, LCD_RW;
  logic [7:0] LCD_DATA;

  textlcd_if #(.AW(4)) host_if ();

  textlcd_ctrl #(
    .COLS(4), .ROWS(2), .TICK_DIV(4), .INIT_STEPS(3), .CLEAR_STEPS(2), .REFRESH_STEPS(5)
  ) dut (
    .clk(clk), .resetn(resetn), .host(host_if),
    .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [8:0] cap_q[$];
  int         cap_t[$];
  logic [8:0] exp_q[$];
  logic [7:0] mdl [8];
  int         e_hi = 0;
  logic [8:0] e_val;

  always @(posedge clk) cyc++;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // E pulse decoder: captures {RS,DATA} on the first high sample, checks hold and width.
  always @(negedge clk) begin
    if (!resetn) begin
      e_hi = 0;
    end else if (LCD_E) begin
      if (e_hi == 0) begin
        e_val = {LCD_RS, LCD_DATA};
        cap_q.push_back(e_val);
        cap_t.push_back(cyc);
        check_val("rw_low", LCD_RW, 0);
      end else begin
        check_val("e_hold", {LCD_RS, LCD_DATA}, e_val);
      end
      e_hi++;
    end else if (e_hi != 0) begin
      check_val("e_width", e_hi, 2);
      e_hi = 0;
    end
  end

  task automatic flush();
    cap_q.delete();
    cap_t.delete();
    exp_q.delete();
  endtask

  task automatic wait_pulses(input int n);
    for (int k = 0; k < 3000 && cap_q.size() < n; k++) begin
      @(negedge clk);
      #1;
    end
    if (cap_q.size() < n) check_val("wait_pulses", cap_q.size(), n);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 3000 && host_if.busy !== 1'b0; k++) begin
      @(negedge clk);
      #1;
    end
    if (host_if.busy !== 1'b0) check_val("wait_idle", host_if.busy, 0);
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d, input logic clr);
    host_if.wr_en     = 1'b1;
    host_if.wr_addr   = a;
    host_if.wr_data   = d;
    host_if.clear_req = clr;
    @(negedge clk);
    host_if.wr_en     = 1'b0;
    host_if.clear_req = 1'b0;
  endtask

  task automatic push_init();
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h006);
    exp_q.push_back(9'h001);
  endtask

  task automatic push_pass();
    exp_q.push_back(9'h080);
    for (int c = 0; c < 4; c++) exp_q.push_back({1'b1, mdl[c]});
    exp_q.push_back(9'h0C0);
    for (int c = 0; c < 4; c++) exp_q.push_back({1'b1, mdl[4+c]});
  endtask

  task automatic check_seq(input string tag);
    check_val({tag, "_cnt"}, cap_q.size() >= exp_q.size(), 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < cap_q.size()) check_val($sformatf("%s[%0d]", tag, i), cap_q[i], exp_q[i]);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    resetn            = 1'b0;
    host_if.wr_en     = 1'b0;
    host_if.wr_addr   = 4'd0;
    host_if.wr_data   = 8'h00;
    host_if.clear_req = 1'b0;
    for (int i = 0; i < 8; i++) mdl[i] = 8'h20;
    repeat (3) @(negedge clk);
    check_val("rst_e", LCD_E, 0);
    check_val("rst_rs", LCD_RS, 0);
    check_val("rst_rw", LCD_RW, 0);
    check_val("rst_data", LCD_DATA, 8'h00);
    check_val("rst_busy", host_if.busy, 1);
    resetn = 1'b1;

    // 1: init commands then a blank pass
    push_init();
    push_pass();
    wait_pulses(14);
    wait_idle();
    check_seq("t1");
    check_val("t1_exact", cap_q.size(), 14);
    if (cap_t.size() >= 5) begin
      check_val("t1_cmd_gap", cap_t[1] - cap_t[0], 4);
      check_val("t1_clr_gap", cap_t[4] - cap_t[3], 12);
    end

    // 2: write while idle triggers a pass quickly
    flush();
    t0 = cyc;
    host_write(4'd5, 8'h41, 1'b0);
    mdl[5] = 8'h41;
    push_pass();
    wait_pulses(10);
    check_seq("t2");
    if (cap_t.size() >= 1) check_val("t2_latency_ok", (cap_t[0] - t0) <= 24, 1);
    wait_idle();

    // 3: write during row-2 chars forces an immediate follow-up pass
    flush();
    push_pass();
    wait_pulses(7);
    host_write(4'd0, 8'h48, 1'b0);
    mdl[0] = 8'h48;
    push_pass();
    wait_pulses(20);
    check_seq("t3");
    if (cap_t.size() >= 11) check_val("t3_gap", cap_t[10] - cap_t[9], 8);
    wait_idle();

    // 4: clear + write same cycle mid-pass
    flush();
    push_pass();
    wait_pulses(3);
    host_write(4'd1, 8'h5A, 1'b1);
    for (int i = 0; i < 8; i++) mdl[i] = 8'h20;
    mdl[1] = 8'h5A;
    for (int i = 0; i < 4; i++) exp_q[6+i] = 9'h120;
    exp_q.push_back(9'h001);
    push_pass();
    wait_pulses(21);
    check_seq("t4");
    if (cap_t.size() >= 12) begin
      check_val("t4_clr_gap", cap_t[10] - cap_t[9], 8);
      check_val("t4_pass_gap", cap_t[11] - cap_t[10], 12);
    end
    wait_idle();

    // 5: out-of-range write is ignored; next pass only after the refresh interval
    flush();
    t0 = cyc;
    host_write(4'd8, 8'h77, 1'b0);
    push_pass();
    wait_pulses(10);
    check_seq("t5");
    if (cap_t.size() >= 1) check_val("t5_refresh_wait", cap_t[0] - t0, 21);
    wait_idle();

    // 6: async reset during an E pulse, then full re-init with blank buffer
    flush();
    wait_pulses(3);
    for (int k = 0; k < 20 && LCD_E !== 1'b1; k++) begin
      @(negedge clk);
      #1;
    end
    check_val("t6_e_before", LCD_E, 1);
    resetn = 1'b0;
    #1;
    check_val("t6_e", LCD_E, 0);
    check_val("t6_rs", LCD_RS, 0);
    check_val("t6_data", LCD_DATA, 8'h00);
    check_val("t6_busy", host_if.busy, 1);
    repeat (3) @(negedge clk);
    flush();
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) mdl[i] = 8'h20;
    push_init();
    push_pass();
    wait_pulses(14);
    wait_idle();
    check_seq("t6");
    check_val("t6_exact", cap_q.size(), 14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
